mmio_bus_initiator: RTL and testbench

//  Bus-master end of the CPU-side memory-mapped I/O interface (12-bit addr, mwe, 32-bit data).

---
 rtl/mmio_pkg.sv | 29 ++
 rtl/mmio_cmd_fifo.sv | 54 +++++
 rtl/mmio_bus_initiator.sv | 157 +++++++++++++++
 tb/tb_mmio_bus_initiator.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO bus initiator: peripheral addresses, FSM encoding
// and the packed command width.
package mmio_pkg;

    localparam logic [11:0] MMIO_ADDR_BTN = 12'd1000;
    localparam logic [11:0] MMIO_ADDR_TEX = 12'd1001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } state_t;

    localparam int MMIO_ADDR_W = 12;
    localparam int MMIO_DATA_W = 32;
    localparam int MMIO_CMD_W  = MMIO_ADDR_W + MMIO_DATA_W + 1;

    // Packed command layout is {we, addr, wdata}.
    function automatic int cmd_width(input int addr_w, input int data_w);
        return addr_w + data_w + 1;
    endfunction

endpackage

// File: rtl/mmio_cmd_fifo.sv
// Synchronous command FIFO; push is ignored when full and pop when empty.
module mmio_cmd_fifo
    import mmio_pkg::*;
#(
    parameter int WIDTH = MMIO_CMD_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mmio_bus_initiator.sv
// MMIO bus master: queues read/write commands, runs each one on the bus and
// returns one in-order response per command.
module mmio_bus_initiator
    import mmio_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_mwe,
    output logic [DATA_W-1:0] bus_data,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    localparam int         CMD_W    = cmd_width(ADDR_W, DATA_W);
    localparam logic [2:0] CNT_INIT = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

    state_t            state;
    state_t            state_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              capture_rdata;
    logic [CMD_W-1:0]  head;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    logic              cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic              mwe_q;
    logic [2:0]        cnt;
    logic              rsp_we_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;

    mmio_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({cmd_we, cmd_addr, cmd_wdata}),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    assign {head_we, head_addr, head_wdata} = head;

    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        capture_rdata = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_we_q || READ_LATENCY == 0) begin
                    capture_rdata = !cmd_we_q;
                    state_next    = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    capture_rdata = 1'b1;
                    state_next    = RESP;
                end
            end
            RESP: begin
                // Popping straight into ISSUE keeps back-to-back commands at two cycles.
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            mwe_q       <= 1'b0;
            cnt         <= 3'd0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state <= state_next;
            // Write strobe is only ever high in the ISSUE cycle that follows a pop.
            mwe_q <= pop && head_we;
            if (pop) begin
                cmd_we_q    <= head_we;
                cmd_addr_q  <= head_addr;
                cmd_wdata_q <= head_wdata;
            end else if (state_next == IDLE) begin
                cmd_we_q    <= 1'b0;
                cmd_addr_q  <= '0;
                cmd_wdata_q <= '0;
            end
            if (state == ISSUE) begin
                cnt <= CNT_INIT;
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == ISSUE && cmd_we_q) begin
                rsp_we_q    <= 1'b1;
                rsp_rdata_q <= cmd_wdata_q;
            end else if (capture_rdata) begin
                rsp_we_q    <= 1'b0;
                rsp_rdata_q <= bus_rdata;
            end
        end
    end

    assign bus_addr  = cmd_addr_q;
    assign bus_data  = cmd_wdata_q;
    assign bus_mwe   = mwe_q;
    assign rsp_valid = (state == RESP);
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mmio_bus_initiator.sv
// Bench for mmio_bus_initiator: three instances with READ_LATENCY 0, 1 and 3,
// a simple MMIO peripheral and an in-order command/response reference model.
module tb_mmio_bus_initiator;
    import mmio_pkg::*;

    localparam int N = 3;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
    } rsp_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]       reset, cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready, rsp_we, bus_mwe, busy;
    logic [N-1:0][11:0] cmd_addr, bus_addr;
    logic [N-1:0][31:0] cmd_wdata, rsp_rdata, bus_data, bus_rdata;
    logic [N-1:0]       stamp;
    logic               mem_clr;

    int pass_cnt = 0;
    int total_cnt = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mmio_bus_initiator #(
            .ADDR_W       (12),
            .DATA_W       (32),
            .FIFO_DEPTH   (4),
            .READ_LATENCY ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) dut (
            .clk       (clk),
            .reset     (reset[g]),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_we    (cmd_we[g]),
            .cmd_addr  (cmd_addr[g]),
            .cmd_wdata (cmd_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_we    (rsp_we[g]),
            .rsp_rdata (rsp_rdata[g]),
            .bus_addr  (bus_addr[g]),
            .bus_mwe   (bus_mwe[g]),
            .bus_data  (bus_data[g]),
            .bus_rdata (bus_rdata[g]),
            .busy      (busy[g])
        );
    end

    function automatic int rl_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    // Unwritten locations: the button reads as BTNU pressed, others as a tagged address.
    function automatic logic [31:0] init_val(input logic [11:0] a);
        return (a == MMIO_ADDR_BTN) ? 32'd1 : (32'hC300_0000 | 32'(a));
    endfunction

    // Peripheral: 16 locations keyed by the low address nibble (addresses 1000..1015).
    logic [31:0] pmem [N][16];
    logic [15:0] pset [N];

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mem_clr) begin
                pset[k] <= '0;
            end else if (bus_mwe[k]) begin
                pmem[k][bus_addr[k][3:0]] <= bus_data[k];
                pset[k][bus_addr[k][3:0]] <= 1'b1;
            end
        end
    end

    always_comb begin
        bus_rdata = '0;
        for (int k = 0; k < N; k++) begin
            if (stamp[k])
                bus_rdata[k] = 32'(cyc);
            else if (pset[k][bus_addr[k][3:0]])
                bus_rdata[k] = pmem[k][bus_addr[k][3:0]];
            else
                bus_rdata[k] = init_val(bus_addr[k]);
        end
    end

    // Reference model: commands take effect in acceptance order.
    logic [31:0] ref_mem [int];
    rsp_t        exp_q [$];
    wr_t         wr_q [$];

    task automatic model_accept(input logic we, input logic [11:0] a, input logic [31:0] d);
        if (we) begin
            ref_mem[int'(a)] = d;
            exp_q.push_back({1'b1, d});
            wr_q.push_back({a, d});
        end else begin
            exp_q.push_back({1'b0, ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a)});
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        mem_clr = 1'b1;
        tick;
        mem_clr = 1'b0;
        ref_mem.delete();
        exp_q.delete();
        wr_q.delete();
    endtask

    task automatic test_reset(input int k);
        cmd_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        reset[k] = 1'b1;
        tick;
        tick;
        total_cnt++; if (cmd_ready[k] !== 1'b1) $display("FAIL reset_cmd_ready dut%0d: got %b want 1", k, cmd_ready[k]); else pass_cnt++;
        total_cnt++; if (rsp_valid[k] !== 1'b0) $display("FAIL reset_rsp_valid dut%0d: got %b want 0", k, rsp_valid[k]); else pass_cnt++;
        total_cnt++; if (bus_mwe[k] !== 1'b0) $display("FAIL reset_bus_mwe dut%0d: got %b want 0", k, bus_mwe[k]); else pass_cnt++;
        total_cnt++; if (busy[k] !== 1'b0) $display("FAIL reset_busy dut%0d: got %b want 0", k, busy[k]); else pass_cnt++;
        total_cnt++; if ({bus_addr[k], bus_data[k]} !== 44'd0) $display("FAIL reset_bus dut%0d: got %h/%h want 0/0", k, bus_addr[k], bus_data[k]); else pass_cnt++;
        total_cnt++; if ({rsp_we[k], rsp_rdata[k]} !== 33'd0) $display("FAIL reset_rsp dut%0d: got %b/%h want 0/0", k, rsp_we[k], rsp_rdata[k]); else pass_cnt++;
        reset[k] = 1'b0;
        tick;
    endtask

    task automatic test_write(input int k);
        int unsigned c;
        int first = -1;
        int mwe_cnt = 0;
        logic bus_ok = 1'b1;
        logic [31:0] rd = '0;
        logic rwe = 1'b0;
        rsp_ready[k] = 1'b1;
        cmd_valid[k] = 1'b1; cmd_we[k] = 1'b1; cmd_addr[k] = MMIO_ADDR_TEX; cmd_wdata[k] = 32'd5;
        c = cyc;
        total_cnt++; if (cmd_ready[k] !== 1'b1) $display("FAIL write_accept dut%0d: cmd_ready %b want 1", k, cmd_ready[k]); else pass_cnt++;
        tick;
        cmd_valid[k] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus_mwe[k]) begin
                mwe_cnt++;
                if (bus_addr[k] !== MMIO_ADDR_TEX || bus_data[k] !== 32'd5) bus_ok = 1'b0;
            end
            if (rsp_valid[k] && first < 0) begin
                first = int'(cyc - c); rd = rsp_rdata[k]; rwe = rsp_we[k];
            end
            tick;
        end
        total_cnt++; if (mwe_cnt != 1) $display("FAIL write_mwe_pulses dut%0d: got %0d want 1", k, mwe_cnt); else pass_cnt++;
        total_cnt++; if (!bus_ok) $display("FAIL write_bus_value dut%0d: addr/data during mwe not 1001/5", k); else pass_cnt++;
        total_cnt++; if (first != 3) $display("FAIL write_latency dut%0d: got %0d want 3", k, first); else pass_cnt++;
        total_cnt++; if ({rwe, rd} !== {1'b1, 32'd5}) $display("FAIL write_rsp dut%0d: got %b/%h want 1/5", k, rwe, rd); else pass_cnt++;
        total_cnt++; if ({rsp_valid[k], busy[k]} !== 2'b00) $display("FAIL write_done dut%0d: valid/busy %b want 00", k, {rsp_valid[k], busy[k]}); else pass_cnt++;
    endtask

    task automatic test_read(input int k);
        int unsigned c;
        int first;
        int mwe_cnt;
        logic [31:0] rd;
        logic rwe;
        clear_model;
        rsp_ready[k] = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            first = -1; mwe_cnt = 0; rd = '0; rwe = 1'b1;
            stamp[k] = (pass == 0);
            cmd_valid[k] = 1'b1; cmd_we[k] = 1'b0; cmd_addr[k] = MMIO_ADDR_BTN; cmd_wdata[k] = 32'hFFFF_FFFF;
            c = cyc;
            tick;
            cmd_valid[k] = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (bus_mwe[k]) mwe_cnt++;
                if (rsp_valid[k] && first < 0) begin
                    first = int'(cyc - c); rd = rsp_rdata[k]; rwe = rsp_we[k];
                end
                tick;
            end
            stamp[k] = 1'b0;
            total_cnt++; if (mwe_cnt != 0) $display("FAIL read_mwe dut%0d: %0d pulses want 0", k, mwe_cnt); else pass_cnt++;
            total_cnt++; if (first != 3 + rl_of(k)) $display("FAIL read_latency dut%0d: got %0d want %0d", k, first, 3 + rl_of(k)); else pass_cnt++;
            if (pass == 0) begin
                total_cnt++; if ({rwe, rd} !== {1'b0, 32'(c + 2 + rl_of(k))}) $display("FAIL read_sample_cycle dut%0d: got %b/%0d want 0/%0d", k, rwe, rd, c + 2 + rl_of(k)); else pass_cnt++;
            end else begin
                total_cnt++; if ({rwe, rd} !== {1'b0, 32'd1}) $display("FAIL read_button dut%0d: got %b/%h want 0/1", k, rwe, rd); else pass_cnt++;
            end
        end
    endtask

    task automatic test_backpressure(input int k);
        logic        c_we [6];
        logic [11:0] c_addr [6];
        logic [31:0] c_data [6];
        logic [31:0] r0;
        logic        w0;
        logic        stable;
        int          mwe_seen, rdy_seen, idx, nrsp;
        rsp_t        got, want;
        clear_model;
        for (int i = 0; i < 6; i++) begin
            c_we[i] = 1'($urandom_range(0, 1)); c_addr[i] = 12'(1000 + $urandom_range(0, 7)); c_data[i] = $urandom;
        end
        idx = 0;
        rsp_ready[k] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cmd_valid[k] = (idx < 6);
            if (idx < 6) begin cmd_we[k] = c_we[idx]; cmd_addr[k] = c_addr[idx]; cmd_wdata[k] = c_data[idx]; end
            if (cmd_valid[k] && cmd_ready[k]) begin model_accept(c_we[idx], c_addr[idx], c_data[idx]); idx++; end
            tick;
        end
        total_cnt++; if (idx != 5) $display("FAIL bp_accepted dut%0d: got %0d want 5", k, idx); else pass_cnt++;
        total_cnt++; if ({cmd_ready[k], rsp_valid[k], busy[k]} !== 3'b011) $display("FAIL bp_full dut%0d: ready/valid/busy %b want 011", k, {cmd_ready[k], rsp_valid[k], busy[k]}); else pass_cnt++;
        r0 = rsp_rdata[k]; w0 = rsp_we[k]; stable = 1'b1; mwe_seen = 0; rdy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid[k] || rsp_rdata[k] !== r0 || rsp_we[k] !== w0) stable = 1'b0;
            if (bus_mwe[k]) mwe_seen++;
            if (cmd_ready[k]) rdy_seen++;
            tick;
        end
        total_cnt++; if (!stable) $display("FAIL hold_stable dut%0d: response changed while stalled (first %b/%h)", k, w0, r0); else pass_cnt++;
        total_cnt++; if (mwe_seen != 0) $display("FAIL hold_mwe dut%0d: %0d pulses want 0", k, mwe_seen); else pass_cnt++;
        total_cnt++; if (rdy_seen != 0) $display("FAIL hold_fifo dut%0d: cmd_ready high %0d cycles want 0", k, rdy_seen); else pass_cnt++;
        rsp_ready[k] = 1'b1; nrsp = 0;
        for (int i = 0; i < 80 && !(idx == 6 && exp_q.size() == 0); i++) begin
            cmd_valid[k] = (idx < 6);
            if (idx < 6) begin cmd_we[k] = c_we[idx]; cmd_addr[k] = c_addr[idx]; cmd_wdata[k] = c_data[idx]; end
            if (rsp_valid[k] && rsp_ready[k]) begin
                nrsp++;
                total_cnt++;
                got = {rsp_we[k], rsp_rdata[k]};
                if (exp_q.size() == 0) $display("FAIL bp_unexpected_rsp dut%0d: got %h with nothing outstanding", k, got);
                else begin
                    want = exp_q.pop_front();
                    if (got !== want) $display("FAIL bp_rsp dut%0d: got %h want %h", k, got, want); else pass_cnt++;
                end
            end
            if (cmd_valid[k] && cmd_ready[k]) begin model_accept(c_we[idx], c_addr[idx], c_data[idx]); idx++; end
            tick;
        end
        cmd_valid[k] = 1'b0;
        total_cnt++; if (idx != 6) $display("FAIL bp_blocked_accept dut%0d: accepted %0d want 6", k, idx); else pass_cnt++;
        total_cnt++; if (nrsp != 6 || exp_q.size() != 0) $display("FAIL bp_rsp_count dut%0d: got %0d want 6 (left %0d)", k, nrsp, exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_back_to_back(input int k);
        int   sent, got_n, period;
        int   t [$];
        logic acc;
        rsp_t got, want;
        for (int pass = 0; pass < 2; pass++) begin
            clear_model;
            rsp_ready[k] = 1'b1; sent = 0; got_n = 0; t.delete();
            period = (pass == 0) ? 2 : 2 + rl_of(k);
            for (int i = 0; i < 60 && got_n < 4; i++) begin
                if (sent < 4 && !cmd_valid[k]) begin
                    cmd_valid[k] = 1'b1; cmd_we[k] = (pass == 0);
                    cmd_addr[k] = 12'(1000 + sent); cmd_wdata[k] = $urandom;
                end
                acc = 1'b0;
                if (rsp_valid[k] && rsp_ready[k]) begin
                    got_n++; t.push_back(int'(cyc));
                    total_cnt++;
                    got = {rsp_we[k], rsp_rdata[k]};
                    if (exp_q.size() == 0) $display("FAIL b2b_unexpected_rsp dut%0d: got %h", k, got);
                    else begin
                        want = exp_q.pop_front();
                        if (got !== want) $display("FAIL b2b_rsp dut%0d: got %h want %h", k, got, want); else pass_cnt++;
                    end
                end
                if (cmd_valid[k] && cmd_ready[k]) begin model_accept(cmd_we[k], cmd_addr[k], cmd_wdata[k]); sent++; acc = 1'b1; end
                tick;
                if (acc) cmd_valid[k] = 1'b0;
            end
            total_cnt++; if (got_n != 4) $display("FAIL b2b_count dut%0d pass%0d: got %0d want 4", k, pass, got_n); else pass_cnt++;
            for (int j = 1; j < t.size(); j++) begin
                total_cnt++; if (t[j] - t[j-1] != period) $display("FAIL b2b_period dut%0d pass%0d: got %0d want %0d", k, pass, t[j] - t[j-1], period); else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_wait(input int k);
        logic any_rsp = 1'b0;
        logic any_mwe = 1'b0;
        clear_model;
        rsp_ready[k] = 1'b1;
        cmd_valid[k] = 1'b1; cmd_we[k] = 1'b0; cmd_addr[k] = MMIO_ADDR_BTN; cmd_wdata[k] = '0;
        tick;
        cmd_we[k] = 1'b1; cmd_addr[k] = MMIO_ADDR_TEX; cmd_wdata[k] = 32'h11;
        tick;
        cmd_wdata[k] = 32'h22;
        tick;
        cmd_valid[k] = 1'b0;
        total_cnt++; if ({bus_addr[k], bus_mwe[k], rsp_valid[k], busy[k]} !== {MMIO_ADDR_BTN, 3'b001}) $display("FAIL rst_pre_wait dut%0d: addr %0d mwe/valid/busy %b want 1000 001", k, bus_addr[k], {bus_mwe[k], rsp_valid[k], busy[k]}); else pass_cnt++;
        reset[k] = 1'b1;
        tick;
        reset[k] = 1'b0;
        total_cnt++; if ({cmd_ready[k], busy[k], rsp_valid[k], bus_mwe[k]} !== 4'b1000) $display("FAIL rst_ctrl dut%0d: ready/busy/valid/mwe %b want 1000", k, {cmd_ready[k], busy[k], rsp_valid[k], bus_mwe[k]}); else pass_cnt++;
        total_cnt++; if ({bus_addr[k], bus_data[k], rsp_we[k], rsp_rdata[k]} !== 77'd0) $display("FAIL rst_data dut%0d: bus %h/%h rsp %b/%h want all 0", k, bus_addr[k], bus_data[k], rsp_we[k], rsp_rdata[k]); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid[k]) any_rsp = 1'b1;
            if (bus_mwe[k]) any_mwe = 1'b1;
            tick;
        end
        total_cnt++; if (any_rsp) $display("FAIL rst_no_rsp dut%0d: response appeared after reset", k); else pass_cnt++;
        total_cnt++; if (any_mwe || busy[k]) $display("FAIL rst_quiet dut%0d: mwe %b busy %b want 0/0", k, any_mwe, busy[k]); else pass_cnt++;
    endtask

    task automatic test_random(input int k);
        logic prev_mwe = 1'b0;
        rsp_t got, want;
        wr_t  bw, wexp;
        clear_model;
        cmd_valid[k] = 1'b0;
        for (int i = 0; i < 360; i++) begin
            if (bus_mwe[k]) begin
                total_cnt++;
                bw = {bus_addr[k], bus_data[k]};
                if (prev_mwe || wr_q.size() == 0) $display("FAIL rand_bus_write dut%0d: unexpected mwe (prev %b, pending %0d) at %h", k, prev_mwe, wr_q.size(), bw);
                else begin
                    wexp = wr_q.pop_front();
                    if (bw !== wexp) $display("FAIL rand_bus_write dut%0d: got %h want %h", k, bw, wexp); else pass_cnt++;
                end
            end
            prev_mwe = bus_mwe[k];
            if (i < 300) begin
                rsp_ready[k] = ($urandom_range(0, 3) != 0);
                if (!cmd_valid[k] && $urandom_range(0, 9) < 6) begin
                    cmd_valid[k] = 1'b1; cmd_we[k] = 1'($urandom_range(0, 1));
                    cmd_addr[k] = 12'(1000 + $urandom_range(0, 7)); cmd_wdata[k] = $urandom;
                end
            end else begin
                rsp_ready[k] = 1'b1;
                cmd_valid[k] = 1'b0;
            end
            if (rsp_valid[k] && rsp_ready[k]) begin
                total_cnt++;
                got = {rsp_we[k], rsp_rdata[k]};
                if (exp_q.size() == 0) $display("FAIL rand_unexpected_rsp dut%0d: got %h", k, got);
                else begin
                    want = exp_q.pop_front();
                    if (got !== want) $display("FAIL rand_rsp dut%0d: got %h want %h", k, got, want); else pass_cnt++;
                end
            end
            if (cmd_valid[k] && cmd_ready[k]) begin
                model_accept(cmd_we[k], cmd_addr[k], cmd_wdata[k]);
                tick;
                cmd_valid[k] = 1'b0;
            end else begin
                tick;
            end
        end
        total_cnt++; if (exp_q.size() != 0 || wr_q.size() != 0) $display("FAIL rand_drain dut%0d: %0d responses and %0d writes outstanding, want 0", k, exp_q.size(), wr_q.size()); else pass_cnt++;
        total_cnt++; if (busy[k] !== 1'b0) $display("FAIL rand_idle dut%0d: busy %b want 0", k, busy[k]); else pass_cnt++;
    endtask

    initial begin
        reset = '1; cmd_valid = '0; cmd_we = '0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = '1; stamp = '0; mem_clr = 1'b0;
        tick; tick; tick;
        reset = '0;
        clear_model;
        for (int k = 0; k < N; k++) begin
            test_reset(k);
            test_write(k);
            test_read(k);
            test_backpressure(k);
            test_back_to_back(k);
            test_random(k);
            if (rl_of(k) > 0) test_reset_wait(k);
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
